// File: rtl/mod_n_detector_seq_pkg.sv
// ----------------------------------------------------------------------------
// mod_det_pkg
// Shared types and helpers for the streaming multiple-of-N detector.
//   state_t  : controller state encoding (IDLE, RUN, DONE)
//   rem_w()  : remainder/accumulator width for a given modulus
//   steps()  : reduction cycles per word
//   DEF_*    : default build configuration, STEPS = its cycle count per word
// ----------------------------------------------------------------------------
package mod_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_DIVISOR      = 5;
    localparam int DEF_BITS_PER_CYC = 1;
    localparam int DEF_DIV_W        = 8;

    // Smallest width that holds every remainder 0..div-1.
    function automatic int rem_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    function automatic int steps(input int data_w, input int bits_per_cyc);
        return data_w / bits_per_cyc;
    endfunction

    localparam int STEPS = steps(DEF_DATA_W, DEF_BITS_PER_CYC);

endpackage

// File: rtl/mod_n_detector_seq_if.sv
// ----------------------------------------------------------------------------
// mod_n_detector_seq_if
// Request/result handshake bundle for mod_n_detector_seq.
//   in_valid/in_ready/din          : word submission
//   out_valid/out_ready/dout/rem   : result return
//   busy                           : detector is reducing a word
//   div/err                        : runtime divisor and bad-divisor flag,
//                                    present only with MODDET_DYN_DIV_EN
// Parameters: DATA_W word width, REM_W remainder width (also div width).
// master = producer/consumer side, slave = detector side.
// ----------------------------------------------------------------------------
interface mod_n_detector_seq_if #(
    parameter int DATA_W = 16,
    parameter int REM_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] din;
    logic              out_valid;
    logic              out_ready;
    logic              dout;
    logic [REM_W-1:0]  rem;
    logic              busy;
`ifdef MODDET_DYN_DIV_EN
    logic [REM_W-1:0]  div;
    logic              err;
`endif

    modport master (
        output in_valid, din, out_ready,
`ifdef MODDET_DYN_DIV_EN
        output div,
        input  err,
`endif
        input  in_ready, out_valid, dout, rem, busy
    );

    modport slave (
        input  in_valid, din, out_ready,
`ifdef MODDET_DYN_DIV_EN
        input  div,
        output err,
`endif
        output in_ready, out_valid, dout, rem, busy
    );

endinterface

// File: rtl/mod_n_detector_seq_step.sv
// ----------------------------------------------------------------------------
// mod_step
// One restoring reduction step: shifts the next word bit into the running
// remainder and subtracts the modulus once if the result reaches it.
//   acc_i [W-1:0] : running remainder, always < d_i
//   bit_i         : next word bit (MSB-first order)
//   d_i   [W:0]   : modulus, one bit wider so a power-of-two modulus fits
//   acc_o [W-1:0] : updated remainder, < d_i
// ----------------------------------------------------------------------------
module mod_step #(
    parameter int W = 3
) (
    input  logic [W-1:0] acc_i,
    input  logic         bit_i,
    input  logic [W:0]   d_i,
    output logic [W-1:0] acc_o
);
    logic [W:0] t;
    logic [W:0] t_sub;

    always_comb begin
        t     = {acc_i, bit_i};
        t_sub = t - d_i;
        acc_o = t[W-1:0];
        // t < 2*d, so one subtraction brings it back below d and into W bits.
        if (t >= d_i) begin
            acc_o = t_sub[W-1:0];
        end
    end

endmodule

// File: rtl/mod_n_detector_seq.sv
// ----------------------------------------------------------------------------
// mod_n_detector_seq
// Streaming multiple-of-N detector. Accepts one DATA_W-bit word, reduces it
// MSB-first BITS_PER_CYC bits per clock, and returns dout (word is a
// multiple of the modulus) plus the remainder.
// Optional build macro MODDET_DYN_DIV_EN: modulus taken from bus.div at
// accept instead of DIVISOR; div < 2 returns err=1 after one clock.
// Ports:
//   clk  : rising-edge clock
//   rstn : synchronous active-low reset
//   bus  : mod_n_detector_seq_if.slave (handshakes, result, busy, div/err)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for a word
// RUN   | reducing the latched word, busy high
// DONE  | result presented with out_valid, held until out_ready
// ----------------------------------------------------------------------------
module mod_n_detector_seq
    import mod_det_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DIVISOR      = DEF_DIVISOR,
    parameter int BITS_PER_CYC = DEF_BITS_PER_CYC,
    parameter int DIV_W        = DEF_DIV_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    mod_n_detector_seq_if.slave   bus
);

`ifdef MODDET_DYN_DIV_EN
    localparam int REM_W = DIV_W;
`else
    localparam int REM_W = rem_w(DIVISOR);
`endif
    localparam int STEPS_L = steps(DATA_W, BITS_PER_CYC);
    localparam int CNT_W   = (STEPS_L > 1) ? $clog2(STEPS_L) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS_L - 1);

    if (((DATA_W % BITS_PER_CYC) != 0) || (DIVISOR < 2) || (DIV_W < 2)) begin : g_cfg_err
        $error("mod_n_detector_seq: unsupported parameter combination");
    end

    state_t              state_q;
    logic [DATA_W-1:0]   sreg_q;
    logic [REM_W-1:0]    acc_q;
    logic [REM_W-1:0]    acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                dout_q;
    logic [REM_W-1:0]    rem_q;
    logic                busy_q;
    logic [REM_W:0]      d_ext;

`ifdef MODDET_DYN_DIV_EN
    logic [REM_W-1:0]    div_q;
    logic                err_q;

    assign d_ext   = {1'b0, div_q};
    assign bus.err = err_q;
`else
    localparam logic [REM_W:0] D_EXT = (REM_W + 1)'(DIVISOR);

    assign d_ext = D_EXT;
`endif

    // Combinational chain: BITS_PER_CYC restoring steps per clock, MSB first.
    logic [REM_W-1:0] chain [0:BITS_PER_CYC];

    assign chain[0] = acc_q;

    for (genvar k = 0; k < BITS_PER_CYC; k++) begin : g_step
        mod_step #(.W(REM_W)) u_step (
            .acc_i (chain[k]),
            .bit_i (sreg_q[DATA_W-1-k]),
            .d_i   (d_ext),
            .acc_o (chain[k+1])
        );
    end

    assign acc_d = chain[BITS_PER_CYC];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= 1'b0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
`ifdef MODDET_DYN_DIV_EN
            div_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sreg_q     <= bus.din;
                        acc_q      <= '0;
                        cnt_q      <= '0;
`ifdef MODDET_DYN_DIV_EN
                        div_q      <= bus.div;
                        if (bus.div < REM_W'(2)) begin
                            // No meaningful modulus: report straight away.
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            dout_q      <= 1'b0;
                            rem_q       <= '0;
                            err_q       <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`endif
                    end
                end

                RUN: begin
                    acc_q  <= acc_d;
                    sreg_q <= sreg_q << BITS_PER_CYC;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        // Result leaves on the same edge as the last step.
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        dout_q      <= (acc_d == '0);
                        rem_q       <= acc_d;
`ifdef MODDET_DYN_DIV_EN
                        err_q       <= 1'b0;
`endif
                    end
                end

                DONE: begin
                    // dout/rem keep the last result after the handshake.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.rem       = rem_q;
    assign bus.busy      = busy_q;

endmodule
